// File: rtl/ahb_led_seq_pkg.sv
// Shared definitions for the AHB-Lite LED sequencer: register offsets, CTRL bit
// positions, counter FSM states and AHB-Lite encodings.
package ahb_led_seq_pkg;

    // Register byte offsets
    localparam logic [7:0] OffCtrl     = 8'h00;
    localparam logic [7:0] OffLoad     = 8'h04;
    localparam logic [7:0] OffValue    = 8'h08;
    localparam logic [7:0] OffPattern  = 8'h0C;
    localparam logic [7:0] OffStatus   = 8'h10;
    localparam logic [7:0] OffPrescale = 8'h14;

    // CTRL layout
    localparam int unsigned CtrlW        = 3;
    localparam int unsigned CtrlEnBit    = 0;
    localparam int unsigned CtrlModeBit  = 1;
    localparam int unsigned CtrlIrqEnBit = 2;

    // AHB-Lite encodings
    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransBusy   = 2'b01;
    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [1:0] HtransSeq    = 2'b11;
    localparam logic [2:0] HsizeWord    = 3'b010;

    typedef enum logic [1:0] {
        StIdle,
        StLoading,
        StRun
    } state_e;

    // Rotate left by one, bit7 wraps to bit0
    function automatic logic [7:0] rotl8(input logic [7:0] v);
        return {v[6:0], v[7]};
    endfunction

endpackage

// File: rtl/led_seq_tick_counter.sv
// Tick counter for the LED sequencer: IDLE/LOADING/RUN FSM, VALUE down-counter
// and tick pulse. Optional prescaler enabled by LED_SEQ_PRESCALE_EN.
module led_seq_tick_counter
    import ahb_led_seq_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] load_i,
`ifdef LED_SEQ_PRESCALE_EN
    input  logic [7:0]       prescale_i,
`endif
    output logic [CNT_W-1:0] value_o,
    output logic             tick_o
);

    state_e           state_q;
    logic [CNT_W-1:0] value_q;
    logic             step;

`ifdef LED_SEQ_PRESCALE_EN
    logic [7:0] psc_q;
    // >= so that lowering PRESCALE mid-run never lets the prescaler wrap
    assign step = (psc_q >= prescale_i);
`else
    assign step = 1'b1;
`endif

    // Tick is decoded from registered state so it lands in the zero-count cycle
    assign tick_o  = (state_q == StRun) && step && (value_q == '0);
    assign value_o = value_q;

    // Counter FSM; clearing EN has priority and freezes VALUE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            value_q <= '0;
`ifdef LED_SEQ_PRESCALE_EN
            psc_q   <= '0;
`endif
        end else if (stop_i) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StLoading;
`ifdef LED_SEQ_PRESCALE_EN
                        psc_q   <= '0;
`endif
                    end
                end
                StLoading: begin
                    state_q <= StRun;
                    value_q <= load_i;
                end
                StRun: begin
`ifdef LED_SEQ_PRESCALE_EN
                    psc_q <= step ? 8'd0 : psc_q + 8'd1;
`endif
                    if (step) begin
                        value_q <= (value_q == '0) ? load_i : value_q - CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/ahb_led_sequencer.sv
// AHB-Lite LED sequencer: bus decode, register file and LED rotator.
// Define LED_SEQ_PRESCALE_EN to add the PRESCALE register at offset 0x14.
module ahb_led_sequencer
    import ahb_led_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic              HREADY,
    input  logic [31:0]       HWDATA,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [7:0]        LED,
    output logic              IRQ
);

    logic              addr_valid;
    logic              dph_valid_q, dph_write_q;
    logic [ADDR_W-1:0] dph_addr_q;
    logic              wr_en, wr_ctrl, wr_load, wr_pattern, wr_status;

    logic [CtrlW-1:0]  ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  load_q, load_d;
    logic [7:0]        pattern_q, pattern_d;
    logic              tick_q, tick_d;
    logic [7:0]        led_q, led_d;
    logic [31:0]       hrdata_q, hrdata_d, rdata;
`ifdef LED_SEQ_PRESCALE_EN
    logic              wr_prescale;
    logic [7:0]        prescale_q, prescale_d;
`endif

    logic              cnt_start, cnt_stop, cnt_tick;
    logic [CNT_W-1:0]  cnt_value;

    assign addr_valid = HSEL & HREADY & ((HTRANS == HtransNonseq) | (HTRANS == HtransSeq))
                        & (HSIZE == HsizeWord);

    // Capture the address phase for use in the following data phase
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dph_valid_q <= 1'b0;
            dph_write_q <= 1'b0;
            dph_addr_q  <= '0;
        end else begin
            dph_valid_q <= addr_valid;
            dph_write_q <= HWRITE;
            dph_addr_q  <= HADDR;
        end
    end

    assign wr_en      = dph_valid_q & dph_write_q;
    assign wr_ctrl    = wr_en & (dph_addr_q == ADDR_W'(OffCtrl));
    assign wr_load    = wr_en & (dph_addr_q == ADDR_W'(OffLoad));
    assign wr_pattern = wr_en & (dph_addr_q == ADDR_W'(OffPattern));
    assign wr_status  = wr_en & (dph_addr_q == ADDR_W'(OffStatus));
`ifdef LED_SEQ_PRESCALE_EN
    assign wr_prescale = wr_en & (dph_addr_q == ADDR_W'(OffPrescale));
`endif

    assign cnt_start = wr_ctrl & HWDATA[CtrlEnBit] & ~ctrl_q[CtrlEnBit];
    assign cnt_stop  = wr_ctrl & ~HWDATA[CtrlEnBit];

    led_seq_tick_counter #(
        .CNT_W(CNT_W)
    ) u_tick_counter (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .start_i    (cnt_start),
        .stop_i     (cnt_stop),
        .load_i     (load_q),
`ifdef LED_SEQ_PRESCALE_EN
        .prescale_i (prescale_q),
`endif
        .value_o    (cnt_value),
        .tick_o     (cnt_tick)
    );

    // Register next-state: PATTERN writes beat rotation, ticks beat TICK clears
    always_comb begin
        ctrl_d    = wr_ctrl    ? HWDATA[CtrlW-1:0] : ctrl_q;
        load_d    = wr_load    ? HWDATA[CNT_W-1:0] : load_q;
        pattern_d = wr_pattern ? HWDATA[7:0]       : pattern_q;
`ifdef LED_SEQ_PRESCALE_EN
        prescale_d = wr_prescale ? HWDATA[7:0] : prescale_q;
`endif
        tick_d = tick_q;
        if (wr_status && HWDATA[0]) tick_d = 1'b0;
        if (cnt_tick)               tick_d = 1'b1;
        led_d = led_q;
        if (wr_pattern) begin
            led_d = HWDATA[7:0];
        end else if (cnt_tick) begin
            led_d = ctrl_q[CtrlModeBit] ? rotl8(led_q) : pattern_q;
        end
    end

    // Read mux; writable registers read through _d so a write in the current
    // data phase is visible to a back-to-back read
    always_comb begin
        rdata = '0;
        case (HADDR)
            ADDR_W'(OffCtrl):     rdata = 32'(ctrl_d);
            ADDR_W'(OffLoad):     rdata = 32'(load_d);
            ADDR_W'(OffValue):    rdata = 32'(cnt_value);
            ADDR_W'(OffPattern):  rdata = 32'(pattern_d);
            ADDR_W'(OffStatus):   rdata = 32'(tick_d);
`ifdef LED_SEQ_PRESCALE_EN
            ADDR_W'(OffPrescale): rdata = 32'(prescale_d);
`endif
            default:              rdata = '0;
        endcase
        hrdata_d = (addr_valid && !HWRITE) ? rdata : '0;
    end

    // Register file, LED register and registered read data
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ctrl_q     <= '0;
            load_q     <= '0;
            pattern_q  <= '0;
            tick_q     <= 1'b0;
            led_q      <= '0;
            hrdata_q   <= '0;
`ifdef LED_SEQ_PRESCALE_EN
            prescale_q <= '0;
`endif
        end else begin
            ctrl_q     <= ctrl_d;
            load_q     <= load_d;
            pattern_q  <= pattern_d;
            tick_q     <= tick_d;
            led_q      <= led_d;
            hrdata_q   <= hrdata_d;
`ifdef LED_SEQ_PRESCALE_EN
            prescale_q <= prescale_d;
`endif
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign LED       = led_q;
    assign IRQ       = tick_q & ctrl_q[CtrlIrqEnBit];

endmodule

// File: doc/ahb_led_sequencer.md
# ahb_led_sequencer

AHB-Lite slave that controls the LED port of the Cortex-M0 system: firmware configures a reload counter and an 8-bit pattern, and the block rotates the pattern on the LED outputs at a programmable tick rate, raising an interrupt per tick. It sits on the AHB-Lite decoder/multiplexer beside the timer and GPIO slaves, and it drives the top-level `LED[7:0]` pins directly.

## Interface
- `ADDR_W`, 8: decoded HADDR bits.
- `CNT_W`, 32: tick counter and LOAD width.
- `CLK` input 1: system clock; all state on rising edge.
- `RESET` input 1: asynchronous, active-high; clears all state.
- `HSEL` input 1: slave select.
- `HADDR` input ADDR_W: byte address, word-aligned.
- `HTRANS` input 2: transfer type; NONSEQ/SEQ = valid.
- `HWRITE` input 1: 1 = write.
- `HSIZE` input 3: only word (3'b010) is supported.
- `HREADY` input 1: bus ready, used to qualify the address phase.
- `HWDATA` input 32: write data in the data phase.
- `HRDATA` output 32: read data.
- `HREADYOUT` output 1: always 1, zero wait states.
- `HRESP` output 1: always 0, OKAY.
- `LED` output 8: LED drive.
- `IRQ` output 1: tick interrupt, level.

## Operation
- Register map (word offsets):
  - 0x00 CTRL: bit0 EN, bit1 MODE (0 = static, 1 = rotate), bit2 IRQ_EN.
  - 0x04 LOAD.
  - 0x08 VALUE: read-only.
  - 0x0C PATTERN: bits [7:0].
  - 0x10 STATUS: bit0 TICK, write-1-to-clear.
- Reads of unmapped offsets return 0. Writes to unmapped offsets are ignored.
- Address phase is captured when `HSEL & HREADY & HTRANS[1]`.
- A write takes effect at the end of its data phase, using `HWDATA`.
- Counter control is a three-state FSM:
  - IDLE → LOADING when EN is written 0→1.
  - LOADING → RUN after one cycle; VALUE is set to LOAD.
  - RUN → IDLE when EN is written 0; VALUE holds its last value.
- In RUN, each cycle: if VALUE==0, generate a tick and reload VALUE=LOAD; otherwise VALUE decrements.
- LOAD=0 gives one tick every cycle.
- Writing LOAD during RUN takes effect only at the next reload.
- On a tick:
  - TICK is set.
  - In MODE=1, the internal LED register rotates left by one (bit7 moves to bit0).
  - In MODE=0, LED stays equal to PATTERN.
- Writing PATTERN loads the LED register immediately, in both modes.
- If a tick and a PATTERN write land in the same cycle, the write wins and no rotation happens that cycle.
- If a tick and a TICK clear land in the same cycle, TICK stays 1.
- `IRQ = TICK & IRQ_EN`, driven from registers.

## Timing
- Reset values:
  - All registers 0.
  - FSM in IDLE.
  - `LED`=0, `IRQ`=0, `HRDATA`=0, `HREADYOUT`=1, `HRESP`=0.
- Read data is registered and valid in the data phase, one cycle after the address phase.
- A read of VALUE returns the counter as it stood at the address-phase edge.
- First tick comes LOAD+2 cycles after the data-phase edge of the EN write: 1 cycle in LOADING, then LOAD+1 cycles of countdown.
- Tick period is LOAD+1 cycles.
- `LED` and `IRQ` update on the clock edge after the tick cycle.
- Asserting RESET mid-count clears everything asynchronously. After release the FSM is in IDLE and requires a fresh EN write.
- Back-to-back transfers are supported with no bubble, and a read after a write to the same register returns the new value.

## Configuration
- `LED_SEQ_PRESCALE_EN` defined:
  - Adds register 0x14 PRESCALE [7:0], reset 0.
  - The counter decrements only once every PRESCALE+1 cycles, so the tick period becomes (LOAD+1)·(PRESCALE+1).
  - The prescaler resets on entering LOADING.
- `LED_SEQ_PRESCALE_EN` undefined:
  - No PRESCALE register; offset 0x14 reads 0.
  - The counter decrements every cycle.

## Structure
- Package `ahb_led_seq_pkg` holds:
  - Register offset constants.
  - CTRL bit indices.
  - FSM state enum (IDLE, LOADING, RUN).
  - HTRANS encodings.
- Sub-module `led_seq_tick_counter` holds the FSM, the VALUE counter, the optional prescaler and the tick pulse output.
- The top level keeps the AHB-Lite decode, the register file and the LED rotator.

## Test plan
- Reset released, no bus traffic → `LED`=0x00, `IRQ`=0, `HREADYOUT`=1, and a read of every register returns 0.
- Write PATTERN=0x81, LOAD=3, then CTRL=0x3 (EN, rotate) → LED reads 0x81, 0x03, 0x06, 0x0C, with a change every 4 cycles and the first change 5 cycles after the CTRL write.
- CTRL=0x5 (EN, IRQ_EN), LOAD=9 → `IRQ` rises 11 cycles after the EN write. Writing STATUS=1 drops `IRQ`, and it rises again 10 cycles later.
- LOAD=0 and EN=1, then STATUS=1 written every cycle → TICK remains 1 (the tick wins), so `IRQ` stays high.
- Rotate mode with LOAD=2 running, PATTERN=0xF0 written on a tick cycle → LED=0xF0, not rotated, then 0xE1 on the next tick.
- With `LED_SEQ_PRESCALE_EN` defined, PRESCALE=1 and LOAD=1 → ticks every 4 cycles. Assert RESET mid-count → LED=0 immediately, and no ticks occur until EN is rewritten.
